// File: rtl/serial_adder_seq_if.sv
// Handshake and data bundle between a requester and the bit-serial adder.
interface serial_adder_seq_if #(
   parameter int W = 8
);
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;

   modport master (
      output start, a_in, b_in, cin,
      input  busy, done, sum_out, cout
   );

   modport slave (
      input  start, a_in, b_in, cin,
      output busy, done, sum_out, cout
   );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: captures two W-bit operands, feeds them LSB-first through
// a 1-bit adder cell with a registered carry, and publishes the W-bit sum plus
// carry-out once all bits have been processed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sum_out/cout hold the previous result
// SHIFT | one operand bit per clock through the adder cell, W clocks
// DONE  | done pulse, result valid; returns to IDLE on the next edge
module serial_adder_seq #(
   parameter int W       = 8,
   parameter bit USE_CIN = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_adder_seq_if.slave  bus
);

   localparam int            CW   = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state_q,  state_d;
   logic [W-1:0]   sh_a_q,   sh_a_d;
   logic [W-1:0]   sh_b_q,   sh_b_d;
   logic [W-1:0]   res_q,    res_d;
   logic           carry_q,  carry_d;
   logic [CW-1:0]  cnt_q,    cnt_d;
   logic [W-1:0]   sum_q,    sum_d;
   logic           cout_q,   cout_d;
   logic           busy_q,   busy_d;
   logic           done_q,   done_d;

   logic           bit_a;
   logic           bit_b;
   logic           bit_s;
   logic           bit_c;
   logic [W:0]     res_ext;

   // 1-bit adder cell plus next-state / next-output selection
   always_comb begin
      state_d = state_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      bit_a   = sh_a_q[0];
      bit_b   = sh_b_q[0];
      bit_s   = bit_a ^ bit_b ^ carry_q;
      bit_c   = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
      // new sum bit enters at the MSB; after W shifts bit 0 lands at the LSB
      res_ext = {bit_s, res_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sh_a_d  = bus.a_in;
               sh_b_d  = bus.b_in;
               // half-adder mode: bit 0 sees a forced-zero carry
               carry_d = USE_CIN ? bus.cin : 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            res_d   = res_ext[W:1];
            carry_d = bit_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = res_ext[W:1];
               cout_d  = bit_c;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // all state and outputs registered; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.sum_out = sum_q;
   assign bus.cout    = cout_q;

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder sequencer that drives the team's 1-bit adder stage (full/half adder selected at elaboration).
- Accepts two W-bit operands in parallel and presents them LSB-first, one bit per clock, to a 1-bit adder cell.
- Holds the carry in a flop between bits and collects the sum bits into a W-bit result with carry-out.
- Sits directly upstream of the 1-bit adder cell and also consumes its outputs; the adder equation is instantiated inside this block.

Parameters:
- W, 8, operand/result width in bits; legal range W >= 1.
- USE_CIN, 0:
  - 1 = full-adder mode; the first bit uses the cin port.
  - 0 = half-adder mode for bit 0; initial carry is forced to 0 and cin is ignored.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a_in  input  W  operand A, captured on the accepting start edge
- b_in  input  W  operand B, captured on the accepting start edge
- cin  input  1  carry-in, captured on the accepting start edge (used only when USE_CIN=1)
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse; sum_out and cout are valid from this cycle onward
- sum_out  output  W  result, A+B(+cin) mod 2^W
- cout  output  1  carry out of bit W-1

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; busy = 0, done = 0, sum_out = 0, cout = 0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
  - Operation resumes on the first rising clk edge after rst_n goes high.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load shA=a_in, shB=b_in, carry=(USE_CIN ? cin : 0), cnt=0; go to SHIFT.
  - On an edge with start=0: remain in IDLE.
- SHIFT (each edge):
  - s = shA[0]^shB[0]^carry; c = majority(shA[0], shB[0], carry).
  - Shift shA and shB right by 1.
  - Shift s into the MSB of the internal result shift register.
  - carry = c; cnt = cnt+1.
  - The edge on which cnt reaches W-1 is the last bit:
    - sum_out <= completed result register including this bit;
    - cout <= c;
    - go to DONE.
  - Exactly W edges are spent in SHIFT.
- DONE:
  - done = 1 for exactly one cycle; on the next edge go to IDLE.
  - start is ignored in SHIFT and DONE; no queuing.
- Latency:
  - start accepted at edge E0; done is high in the cycle after edge EW, i.e. W+1 cycles after acceptance.
  - Minimum start-to-start spacing: W+2 cycles.
- sum_out and cout hold their last values until the final SHIFT edge of the next operation; they do not change on start.
- busy is registered: high in the cycle after the accepting edge, low in the cycle after DONE.
- W=1:
  - exactly one SHIFT edge; cnt is 0 on that edge, so it is the last bit;
  - sum_out = a^b^carry, cout = majority(a, b, carry).
- Operand inputs and cin may change freely after the accepting edge; they are not resampled.
- The bit counter is wide enough to hold W-1 without overflow (ceil(log2(W+1)) bits).

Test Plan:
- Reset then idle:
  - rst_n low for 3 cycles, then start=0 for 5 cycles -> busy=0, done=0, sum_out=0, cout=0 throughout.
- Basic add, W=8, USE_CIN=0:
  - a=8'h35, b=8'h4A, cin=1 -> done exactly 9 cycles after the start edge;
  - sum_out=8'h7F, cout=0 (cin ignored).
- Carry chain and carry-out, W=8, USE_CIN=1:
  - a=8'hFF, b=8'h00, cin=1 -> sum_out=8'h00, cout=1.
  - Then a=8'hC8, b=8'h64, cin=0 -> sum_out=8'h2C, cout=1.
- Start ignored while busy:
  - pulse start again at cycles 3 and 9 of an operation with a=8'h01, b=8'h01 -> single done, sum_out=8'h02;
  - new operands are not captured; start is accepted again only after busy falls.
- Reset mid-operation:
  - rst_n low after 4 SHIFT cycles -> busy, done, sum_out and cout go to 0 immediately (asynchronous);
  - no done pulse; a subsequent a=8'h10, b=8'h20 yields sum_out=8'h30.
- W=1, USE_CIN=1, all 8 combinations of a, b, cin:
  - each completes with done 2 cycles after start;
  - {cout, sum_out} = a+b+cin.
